// File: rtl/popcount_seq.sv
// Burst popcount sequencer: streams 8-bit words through an 8-to-4 compressor,
// accumulates the per-word counts and presents the total with a threshold compare.

module adder_8to4 (
  input  logic [7:0] in_word,
  output logic [3:0] cnt
);
  logic [1:0] s01, s23, s45, s67;
  logic [2:0] s0123, s4567;

  always_comb begin
    s01   = {1'b0, in_word[0]} + {1'b0, in_word[1]};
    s23   = {1'b0, in_word[2]} + {1'b0, in_word[3]};
    s45   = {1'b0, in_word[4]} + {1'b0, in_word[5]};
    s67   = {1'b0, in_word[6]} + {1'b0, in_word[7]};
    s0123 = {1'b0, s01} + {1'b0, s23};
    s4567 = {1'b0, s45} + {1'b0, s67};
    cnt   = {1'b0, s0123} + {1'b0, s4567};
  end
endmodule

module popcount_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ACC_W-1:0] thr,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_act
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting words, accumulating the previous one
  // DRAIN | final accumulate of the last word
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  generate
    if (ACC_W < LEN_W + 4) begin : g_bad_acc_w
      $error("popcount_seq: ACC_W must be at least LEN_W+4");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic [ACC_W-1:0] thr_q;
  logic [ACC_W-1:0] acc;
  logic [7:0]       word;
  logic             word_vld;
  logic [3:0]       word_cnt;
  logic             launch;
  logic             accept;

  adder_8to4 u_adder (
    .in_word (word),
    .cnt     (word_cnt)
  );

  assign launch = (state == IDLE) && start;
  assign accept = (state == RUN) && in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (in_valid && rem == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      thr_q    <= '0;
      acc      <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_vld <= accept;
      if (launch) begin
        rem   <= len;
        thr_q <= thr;
      end else if (accept) begin
        rem <= rem - LEN_W'(1);
      end
      if (accept) word <= in_data;
      // word_vld is never set in IDLE, so the launch clear cannot collide with an add
      if (launch)
        acc <= '0;
      else if (word_vld)
        acc <= acc + {{(ACC_W-4){1'b0}}, word_cnt};
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_act   = (state == DONE) && (acc >= thr_q);
endmodule
